// File: rtl/comparator.sv
// comparator: registered equality/magnitude compare of x and y with a valid strobe
module comparator #(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             en,
    output logic             z,
    output logic             gt,
    output logic             lt,
    output logic             valid
);
    localparam logic [WIDTH-1:0] MSB = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    logic [WIDTH-1:0] xb, yb;
    assign xb = x ^ MSB;
    assign yb = y ^ MSB;
    // sign-bit flip turns two's-complement ordering into unsigned ordering; flags hold while en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z     <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                z  <= x == y;
                gt <= xb > yb;
                lt <= xb < yb;
            end
        end
    end
endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed checks of the comparator across unsigned/signed and 1/4-bit configs
module tb_comparator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       z1, gt1, lt1, v1;
    logic       zs, gts, lts, vs;
    logic       zu, gtu, ltu, vu;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    comparator #(.WIDTH(1), .SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n), .x(a1), .y(b1), .en(en),
        .z(z1), .gt(gt1), .lt(lt1), .valid(v1));
    comparator #(.WIDTH(4), .SIGNED(1)) us (.clk(clk), .rst_n(rst_n), .x(a4), .y(b4), .en(en),
        .z(zs), .gt(gts), .lt(lts), .valid(vs));
    comparator #(.WIDTH(4), .SIGNED(0)) uu (.clk(clk), .rst_n(rst_n), .x(a4), .y(b4), .en(en),
        .z(zu), .gt(gtu), .lt(ltu), .valid(vu));

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b0; en = 1'b1; rst_n = 1'b0;
        #2;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b0000)
            $display("FAIL reset_w1 got zgtltv=%b want 0000", {z1, gt1, lt1, v1});
        else passed++;
        total++;
        if ({zs, gts, lts, vs, zu, gtu, ltu, vu} !== 8'h00)
            $display("FAIL reset_w4 got %b want 00000000", {zs, gts, lts, vs, zu, gtu, ltu, vu});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b0000)
            $display("FAIL reset_held_edge got zgtltv=%b want 0000", {z1, gt1, lt1, v1});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b1001)
            $display("FAIL equal_00 got zgtltv=%b want 1001", {z1, gt1, lt1, v1});
        else passed++;
    endtask

    task automatic test_sequence();
        logic [1:0] xy [3] = '{2'b10, 2'b11, 2'b10};
        logic [3:0] exp [3] = '{4'b0101, 4'b1001, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {a1, b1} = xy[i]; en = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({z1, gt1, lt1, v1} !== exp[i])
                $display("FAIL seq_%0d got zgtltv=%b want %b", i, {z1, gt1, lt1, v1}, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0; a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b0100)
            $display("FAIL hold got zgtltv=%b want 0100", {z1, gt1, lt1, v1});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b0100)
            $display("FAIL hold_2 got zgtltv=%b want 0100", {z1, gt1, lt1, v1});
        else passed++;
    endtask

    task automatic test_signed();
        logic [3:0] xa [5] = '{4'hF, 4'h7, 4'hA, 4'h8, 4'h0};
        logic [3:0] ya [5] = '{4'h1, 4'h8, 4'hA, 4'hF, 4'h0};
        logic [3:0] es [5] = '{4'b0011, 4'b0101, 4'b1001, 4'b0011, 4'b1001};
        logic [3:0] eu [5] = '{4'b0101, 4'b0011, 4'b1001, 4'b0011, 4'b1001};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = xa[i]; b4 = ya[i]; en = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({zs, gts, lts, vs} !== es[i])
                $display("FAIL signed_%0d x=%h y=%h got zgtltv=%b want %b", i, xa[i], ya[i], {zs, gts, lts, vs}, es[i]);
            else passed++;
            total++;
            if ({zu, gtu, ltu, vu} !== eu[i])
                $display("FAIL unsigned_%0d x=%h y=%h got zgtltv=%b want %b", i, xa[i], ya[i], {zu, gtu, ltu, vu}, eu[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] xy [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        logic [3:0] exp [4] = '{4'b0011, 4'b1001, 4'b0101, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1} = xy[i]; en = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({z1, gt1, lt1, v1} !== exp[i])
                $display("FAIL b2b_%0d got zgtltv=%b want %b", i, {z1, gt1, lt1, v1}, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; a4 = 4'h3; b4 = 4'h2; en = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1, vs, vu} !== 6'b010111)
            $display("FAIL pre_async got %b want 010111", {z1, gt1, lt1, v1, vs, vu});
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({z1, gt1, lt1, v1, zs, gts, lts, vs, zu, gtu, ltu, vu} !== 12'h000)
            $display("FAIL async_reset got %b want 000000000000", {z1, gt1, lt1, v1, zs, gts, lts, vs, zu, gtu, ltu, vu});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({z1, gt1, lt1, v1} !== 4'b0101)
            $display("FAIL post_async got zgtltv=%b want 0101", {z1, gt1, lt1, v1});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_equal();
        test_sequence();
        test_hold();
        test_signed();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
